// File: rtl/mem_arbiter.sv
// Arbitrates a single-port, variable-latency memory between instruction fetch (read-only)
// and the data-memory stage, with round-robin on collisions and a per-access timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ready,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    input  logic [DATA_W/8-1:0] dm_be,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stall,
    output logic                timeout_err
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic              grantIf;
    logic              grantDm;
    logic              accessEnd;
    logic              timeoutHit;
    logic [CNT_W-1:0]  waitCnt;
    logic              owner;      // 1 = data stage owns the access
    logic              lastGrant;  // 1 = data stage was granted last
    logic [DATA_W-1:0] rdCapture;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state, grant and completion decode
    always_comb begin
        stateNext  = state;
        grantIf    = 1'b0;
        grantDm    = 1'b0;
        accessEnd  = 1'b0;
        timeoutHit = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_req && dm_req) begin
                    if (lastGrant) begin
                        grantIf = 1'b1;
                    end else begin
                        grantDm = 1'b1;
                    end
                end else if (dm_req) begin
                    grantDm = 1'b1;
                end else if (if_req) begin
                    grantIf = 1'b1;
                end
                if (grantIf || grantDm) begin
                    stateNext = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    accessEnd = 1'b1;
                    stateNext = DONE;
                end else if (waitCnt == CNT_W'(MAX_WAIT - 1)) begin
                    timeoutHit = 1'b1;
                    accessEnd  = 1'b1;
                    stateNext  = DONE;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign rdCapture = timeoutHit ? '0 : mem_rdata;

    // Memory-side request registers, response capture and ready pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            if_ready    <= 1'b0;
            dm_ready    <= 1'b0;
            timeout_err <= 1'b0;
            waitCnt     <= '0;
            owner       <= 1'b0;
            lastGrant   <= 1'b0;
        end else begin
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            if (grantIf || grantDm) begin
                mem_req   <= 1'b1;
                mem_we    <= grantDm ? dm_we : 1'b0;
                mem_addr  <= grantDm ? dm_addr : if_addr;
                mem_wdata <= grantDm ? dm_wdata : '0;
                mem_be    <= grantDm ? dm_be : {BE_W{1'b1}};
                owner     <= grantDm;
                lastGrant <= grantDm;
                waitCnt   <= '0;
            end
            if (state == BUSY) begin
                waitCnt <= waitCnt + CNT_W'(1);
            end
            if (accessEnd) begin
                mem_req <= 1'b0;
                mem_we  <= 1'b0;
                if (timeoutHit) begin
                    timeout_err <= 1'b1;
                end
                if (owner) begin
                    dm_ready <= 1'b1;
                    // A store that completes normally leaves the load data untouched
                    if (timeoutHit || !mem_we) begin
                        dm_rdata <= rdCapture;
                    end
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= rdCapture;
                end
            end
        end
    end

    assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);

endmodule
